// File: rtl/uart_rx_8e1.sv
// UART receiver, 8 data bits LSB-first, one stop bit, mid-bit sampling with a 2-FF input synchronizer.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit checked); undefined gives 8N1.
module uart_rx_8e1 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_line,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic          done_q, done_d;
  logic          sync1_q, line_s;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      line_s  <= 1'b1;
    end else begin
      sync1_q <= i_line;
      line_s  <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (line_s) state_d = IDLE;
      end
      // IDLE is only ever entered with the line seen high, so a low sample here is the falling edge.
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!line_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = line_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {line_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          perr_d  = (^shift_q) ^ line_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          ferr_d  = ~line_s;
          done_d  = 1'b1;
          state_d = line_s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= done_q;
      if (done_q) begin
        o_data      <= shift_q;
        o_frame_err <= ferr_q;
`ifdef UART_RX_PARITY_EN
        o_parity_err <= perr_q;
`else
        o_parity_err <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    o_busy = (state_q != WAIT_IDLE) && (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_8e1.sv
// Scoreboard bench for uart_rx_8e1: driver queues expected frames, a negedge monitor checks every o_valid
// plus output hold between pulses; directed cases first, then randomized frames.
module tb_uart_rx_8e1;

  localparam int unsigned N = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned NOM_LAT = 2 + N / 2 + (PAR_EN ? 10 : 9) * N;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_busy;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        q[$];
  logic [9:0]  last = '0;

  uart_rx_8e1 #(.CLKS_PER_BIT(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_line      (line),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input int unsigned cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Expected result comes from the frame content: receiver parity error iff the sent parity bit was corrupted.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = PAR_EN ? bad_par : 1'b0;
    e.ferr = ~stop;
    e.fall = cyc + 1;
    q.push_back(e);
    line = 1'b0;
    hold(N);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      hold(N);
    end
    if (PAR_EN) begin
      line = (^d) ^ bad_par;
      hold(N);
    end
    line = stop;
    hold(N);
  endtask

  initial begin : monitor
    exp_t e;
    int unsigned lat;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", 32'(o_data), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            lat = cyc - e.fall;
            chk("data", 32'(o_data), 32'(e.data));
            chk("parity_err", 32'(o_parity_err), 32'(e.perr));
            chk("frame_err", 32'(o_frame_err), 32'(e.ferr));
            chk("latency_in_window", 32'(lat), (lat + 1 >= NOM_LAT && lat <= NOM_LAT + 1) ? 32'(lat) : 32'(NOM_LAT));
            last = {e.data, e.perr, e.ferr};
          end
        end else begin
          chk("hold_outputs", 32'({o_data, o_parity_err, o_frame_err}), 32'(last));
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] d;
    logic       bp, sb;
    int unsigned gap;

    hold(3);
    chk("reset_outputs", 32'({o_data, o_valid, o_parity_err, o_frame_err, o_busy}), 32'd0);
    rst_n = 1'b1;
    hold(2 * N + 5);

    send_frame(8'hA5, 1'b0, 1'b1);
    hold(3 * N);
    send_frame(8'h01, 1'b1, 1'b1);
    hold(2 * N);

    // short glitch: rejected at mid start bit
    line = 1'b0;
    hold(4);
    chk("glitch_busy_high", 32'(o_busy), 32'd1);
    hold(2);
    line = 1'b1;
    hold(8);
    chk("glitch_busy_low", 32'(o_busy), 32'd0);
    hold(2 * N);

    // bad stop then break: one frame only
    send_frame(8'h3C, 1'b0, 1'b0);
    line = 1'b0;
    hold(40 * N);
    chk("break_not_busy", 32'(o_busy), 32'd0);
    line = 1'b1;
    hold(3 * N);
    chk("break_idle_not_busy", 32'(o_busy), 32'd0);
    send_frame(8'h96, 1'b0, 1'b1);
    hold(N);

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    hold(2 * N);

    // reset in the middle of DATA of 0x55
    line = 1'b0;
    hold(N);
    line = 1'b1;
    hold(N);
    line = 1'b0;
    hold(N);
    line = 1'b1;
    hold(N / 2);
    chk("busy_mid_frame", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    last = '0;
    #1;
    chk("async_reset_outputs", 32'({o_data, o_valid, o_parity_err, o_frame_err, o_busy}), 32'd0);
    hold(3);
    rst_n = 1'b1;
    hold(2 * N);
    send_frame(8'h81, 1'b0, 1'b1);
    hold(2 * N);

    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(d, bp, sb);
      line = 1'b1;
      gap  = sb ? $urandom_range(1, 2 * N) : N + $urandom_range(0, N);
      hold(gap);
    end

    hold(4 * N);
    chk("all_frames_seen", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_8e1.md
UART_RX_8E1 -- requirements
Module: uart_rx_8e1

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: i_clk cycles per serial bit; legal range 4..1023.
REQ-002 SHALL have port i_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port i_line, input, 1 bit: asynchronous serial input, idle high (fed by the TX o_line).
REQ-005 SHALL have port o_data, output, 8 bits: last received byte.
REQ-006 SHALL have port o_valid, output, 1 bit: one-cycle pulse when o_data and error flags update.
REQ-007 SHALL have port o_parity_err, output, 1 bit: last frame failed the even-parity check.
REQ-008 SHALL have port o_frame_err, output, 1 bit: last frame's stop bit sampled low.
REQ-009 SHALL have port o_busy, output, 1 bit: high in states START, DATA, PARITY and STOP.

Function
REQ-010 SHALL pass i_line through a 2-FF synchronizer; both FFs reset to 1; all logic uses the synchronized line only.
REQ-011 SHALL implement states WAIT_IDLE, IDLE, START, DATA, PARITY, STOP with a bit-time counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index.
REQ-012 WAIT_IDLE -> IDLE on the first cycle the synchronized line is 1.
REQ-013 IDLE -> START on a synchronized falling edge (previous 1, current 0); counter cleared.
REQ-014 START: at counter = CLKS_PER_BIT/2-1 (integer division), sample the line; 0 -> DATA with counter cleared; 1 -> IDLE, glitch rejected, no output change.
REQ-015 DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift LSB-first into an 8-bit register; after the 8th sample -> PARITY, or -> STOP if parity is compiled out.
REQ-016 PARITY: sample one bit CLKS_PER_BIT cycles later; parity error = XOR of the 8 data bits XOR the sampled bit.
REQ-017 STOP: sample CLKS_PER_BIT cycles later; on the next edge load o_data, o_parity_err and o_frame_err and pulse o_valid for exactly one cycle.
REQ-018 SHALL pulse o_valid for erroneous frames too; the flags qualify the byte.
REQ-019 o_data and both flags SHALL hold their values until the next o_valid.
REQ-020 After STOP: stop bit 1 -> IDLE immediately at mid-stop, so a back-to-back start edge is accepted. Stop bit 0 -> WAIT_IDLE, so a break or held-low line produces one frame only.
REQ-021 Latency: o_valid SHALL rise 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT (+/-1) cycles after the i_line start-bit falling edge with parity enabled, or 9*CLKS_PER_BIT without.
REQ-022 SHALL ignore a preceding idle mark bit of any length; frame alignment comes only from the start edge.

Reset
REQ-023 Asserting i_rst_n low SHALL immediately force o_data=0x00, o_valid=0, o_parity_err=0, o_frame_err=0 and o_busy=0, with state WAIT_IDLE and counters cleared.
REQ-024 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL resume only after the line is seen high, then a fresh falling edge arrives.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: frame is start + 8 data + even parity + stop (8E1), matching the TX.
REQ-026 Macro UART_RX_PARITY_EN undefined: frame is 8N1, the PARITY state is removed and o_parity_err is tied 0.

Verification (CLKS_PER_BIT=16, UART_RX_PARITY_EN defined unless stated)
REQ-027 Idle mark, then start, 0xA5, parity 0, stop 1 -> one o_valid; o_data=0xA5, parity and frame flags 0; latency per REQ-021.
REQ-028 0x01 sent with parity bit 0 -> o_valid, o_data=0x01, o_parity_err=1.
REQ-029 0x3C with stop bit 0, line then held low for 40 bit-times -> exactly one o_valid with o_frame_err=1; no second frame until the line is high and a new edge arrives.
REQ-030 6-cycle low glitch on an idle line -> no o_valid; o_busy falls back to 0 within 10 cycles.
REQ-031 Back-to-back frames 0x00 then 0xFF with no idle gap -> two o_valid pulses, data 0x00 then 0xFF, no flags set.
REQ-032 i_rst_n low during DATA of 0x55 -> all outputs 0 at once; the next full frame 0x81 is received correctly. With the macro undefined, 8N1 frame 0x81 -> o_data=0x81, o_parity_err=0.
